// File: rtl/transaction_sequencer.sv
// -----------------------------------------------------------------------------
// transaction_sequencer
//   Control FSM for the coin transaction flow. A transaction runs NUM_STEPS
//   datapath steps, each preceded by a travel phase. Each phase can time out,
//   and the controller can abort the transaction. A step can report failure.
//   Completion raises a 1-cycle txn_done pulse. An error exit raises a 1-cycle
//   txn_error pulse, and err_code keeps the cause until the next accepted start.
//
// Ports
//   clock             rising-edge clock
//   resetn            asynchronous active-low reset
//   start_transaction start request, sampled in IDLE only
//   done_travel       travel phase complete, sampled in TRAVEL only
//   done_step         step complete, sampled in STEP only
//   step_ok           step result qualified by done_step (1 = pass)
//   abort             cancel the in-flight transaction (TRAVEL/STEP only)
//   step              active step index 1..NUM_STEPS in TRAVEL/STEP, else 0
//   travel            active travel index 1..NUM_STEPS in TRAVEL, else 0
//   busy              high in TRAVEL or STEP
//   txn_done          1-cycle pulse, all steps passed
//   txn_error         1-cycle pulse, transaction ended on an error
//   err_code          00 none, 01 step fail, 10 timeout, 11 abort
// -----------------------------------------------------------------------------
module transaction_sequencer #(
  parameter int NUM_STEPS      = 4,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start_transaction,
  input  logic             done_travel,
  input  logic             done_step,
  input  logic             step_ok,
  input  logic             abort,
  output logic [IDX_W-1:0] step,
  output logic [IDX_W-1:0] travel,
  output logic             busy,
  output logic             txn_done,
  output logic             txn_error,
  output logic [1:0]       err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRAVEL, S_STEP, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STEP  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t           state, nxt_state;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [1:0]       nxt_err;
  logic [CNT_W-1:0] timer;
  logic             tmo;

  // The last permitted cycle of the phase. A completing input seen in the
  // same cycle still takes priority over the timeout.
  assign tmo = TMO_EN && (timer == TMO_LAST);

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_err   = err_code;
    case (state)
      S_IDLE: begin
        if (start_transaction) begin
          nxt_state = S_TRAVEL;
          nxt_idx   = IDX_W'(1);
          nxt_err   = ERR_NONE;
        end
      end
      S_TRAVEL: begin
        if (abort) begin
          nxt_state = S_ERROR;
          nxt_err   = ERR_ABORT;
        end else if (done_travel) begin
          nxt_state = S_STEP;
        end else if (tmo) begin
          nxt_state = S_ERROR;
          nxt_err   = ERR_TMO;
        end
      end
      S_STEP: begin
        if (abort) begin
          nxt_state = S_ERROR;
          nxt_err   = ERR_ABORT;
        end else if (done_step) begin
          if (!step_ok) begin
            nxt_state = S_ERROR;
            nxt_err   = ERR_STEP;
          end else if (idx == LAST_IDX) begin
            nxt_state = S_DONE;
          end else begin
            nxt_state = S_TRAVEL;
            nxt_idx   = idx + 1'b1;
          end
        end else if (tmo) begin
          nxt_state = S_ERROR;
          nxt_err   = ERR_TMO;
        end
      end
      S_DONE, S_ERROR: nxt_state = S_IDLE;
      default:         nxt_state = S_IDLE;
    endcase
    // The index is only meaningful while a phase is active.
    if (nxt_state != S_TRAVEL && nxt_state != S_STEP) nxt_idx = '0;
  end

  // State, timer and outputs are registered together. The outputs decode the
  // next state, so they line up with the state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      timer     <= '0;
      err_code  <= ERR_NONE;
      step      <= '0;
      travel    <= '0;
      busy      <= 1'b0;
      txn_done  <= 1'b0;
      txn_error <= 1'b0;
    end else begin
      state    <= nxt_state;
      idx      <= nxt_idx;
      err_code <= nxt_err;
      // The timer restarts on every phase entry, including TRAVEL->STEP.
      if (nxt_state != state || (state != S_TRAVEL && state != S_STEP))
        timer <= '0;
      else
        timer <= timer + 1'b1;
      step      <= (nxt_state == S_TRAVEL || nxt_state == S_STEP) ? nxt_idx : '0;
      travel    <= (nxt_state == S_TRAVEL) ? nxt_idx : '0;
      busy      <= (nxt_state == S_TRAVEL || nxt_state == S_STEP);
      txn_done  <= (nxt_state == S_DONE);
      txn_error <= (nxt_state == S_ERROR);
    end
  end

endmodule

// File: tb/tb_transaction_sequencer.sv
module tb_transaction_sequencer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_transaction = 1'b0;
  logic       done_travel = 1'b0;
  logic       done_step = 1'b0;
  logic       step_ok = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] step, travel;
  logic       busy, txn_done, txn_error;
  logic [1:0] err_code;

  transaction_sequencer #(
    .NUM_STEPS(4), .IDX_W(3), .TIMEOUT_CYCLES(8), .CNT_W(16)
  ) dut (
    .clock(clock), .resetn(resetn), .start_transaction(start_transaction),
    .done_travel(done_travel), .done_step(done_step), .step_ok(step_ok),
    .abort(abort), .step(step), .travel(travel), .busy(busy),
    .txn_done(txn_done), .txn_error(txn_error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       is_done;
    logic [1:0] code;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input int s, input int t, input int b);
    chk({nm, ".step"}, 32'(step), 32'(s));
    chk({nm, ".travel"}, 32'(travel), 32'(t));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic push(input logic d, input logic [1:0] c, input string nm);
    exp_t e;
    e.is_done = d;
    e.code    = c;
    e.name    = nm;
    q.push_back(e);
  endtask

  task automatic do_start();
    start_transaction = 1'b1; tick(); start_transaction = 1'b0;
  endtask
  task automatic do_travel();
    done_travel = 1'b1; tick(); done_travel = 1'b0;
  endtask
  task automatic do_step(input logic ok);
    done_step = 1'b1; step_ok = ok; tick(); done_step = 1'b0; step_ok = 1'b0;
  endtask
  task automatic do_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Monitor: every done/error pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      tick();
      if (txn_done || txn_error) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_pulse: got done=%0b error=%0b code=%0d expected no pulse",
                   txn_done, txn_error, err_code);
        end else begin
          e = q.pop_front();
          chk({e.name, ".done"}, 32'(txn_done), 32'(e.is_done));
          chk({e.name, ".error"}, 32'(txn_error), 32'(!e.is_done));
          chk({e.name, ".code"}, 32'(err_code), 32'(e.code));
          chk({e.name, ".pulse_step"}, 32'(step), 32'd0);
          chk({e.name, ".pulse_busy"}, 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    expect_out("reset", 0, 0, 0);
    chk("reset.done", 32'(txn_done), 0);
    chk("reset.error", 32'(txn_error), 0);
    chk("reset.code", 32'(err_code), 0);
    @(negedge clock); resetn = 1'b1;
    tick();
    expect_out("idle", 0, 0, 0);

    // 1 Nominal: one cycle per phase, 1,1,2,2,3,3,4,4 then DONE
    push(1'b1, 2'b00, "nominal");
    do_start();
    expect_out("nom.t1", 1, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      do_travel();
      expect_out($sformatf("nom.s%0d", i), i, 0, 1);
      do_step(1'b1);
      if (i < 4) expect_out($sformatf("nom.t%0d", i + 1), i + 1, i + 1, 1);
      else       expect_out("nom.done", 0, 0, 0);
    end
    tick();
    expect_out("nom.idle", 0, 0, 0);
    chk("nom.code", 32'(err_code), 0);

    // 2 Step failure at step 2
    do_start(); do_travel(); do_step(1'b1); do_travel();
    expect_out("fail.s2", 2, 0, 1);
    push(1'b0, 2'b01, "stepfail");
    do_step(1'b0);
    expect_out("fail.err", 0, 0, 0);
    tick();
    expect_out("fail.idle", 0, 0, 0);
    chk("fail.held", 32'(err_code), 1);

    // 6 Ignored inputs: abort in IDLE keeps err_code; start clears it
    do_abort();
    expect_out("ign.abort_idle", 0, 0, 0);
    chk("ign.abort_code", 32'(err_code), 1);
    do_start();
    chk("ign.start_clear", 32'(err_code), 0);
    do_step(1'b1);
    expect_out("ign.step_in_travel", 1, 1, 1);
    do_start();
    expect_out("ign.start_busy", 1, 1, 1);
    do_travel();
    done_travel = 1'b1; tick(); done_travel = 1'b0;
    expect_out("ign.travel_in_step", 1, 0, 1);

    // 4 Abort outranks a passing done_step at step 4
    do_step(1'b1); do_travel(); do_step(1'b1); do_travel(); do_step(1'b1); do_travel();
    expect_out("abt.s4", 4, 0, 1);
    push(1'b0, 2'b11, "abort_prio");
    done_step = 1'b1; step_ok = 1'b1; abort = 1'b1;
    tick();
    done_step = 1'b0; step_ok = 1'b0; abort = 1'b0;
    expect_out("abt.err", 0, 0, 0);
    tick();
    chk("abt.code", 32'(err_code), 3);

    // 3 Timeout in TRAVEL after exactly 8 cycles
    do_start();
    for (int k = 0; k < 7; k++) tick();
    expect_out("tmo.cycle8", 1, 1, 1);
    push(1'b0, 2'b10, "timeout_travel");
    tick();
    expect_out("tmo.err", 0, 0, 0);
    tick();
    chk("tmo.code", 32'(err_code), 2);
    // done_travel on cycle 8 wins, then STEP itself times out
    do_start();
    for (int k = 0; k < 7; k++) tick();
    do_travel();
    expect_out("tmo.win", 1, 0, 1);
    for (int k = 0; k < 7; k++) tick();
    expect_out("tmo.step8", 1, 0, 1);
    push(1'b0, 2'b10, "timeout_step");
    tick();
    expect_out("tmo.step_err", 0, 0, 0);
    tick();

    // 5 Async reset mid STEP 3, away from a clock edge
    do_start(); do_travel(); do_step(1'b1); do_travel(); do_step(1'b1); do_travel();
    expect_out("rst.s3", 3, 0, 1);
    #2 resetn = 1'b0;
    #1;
    expect_out("rst.async", 0, 0, 0);
    chk("rst.code", 32'(err_code), 0);
    #2 resetn = 1'b1;
    do_start();
    expect_out("rst.restart", 1, 1, 1);
    push(1'b0, 2'b11, "abort_after_reset");
    do_abort();
    tick();

    // Back-to-back: start held from the final step through DONE
    do_start();
    for (int i = 1; i <= 3; i++) begin do_travel(); do_step(1'b1); end
    do_travel();
    push(1'b1, 2'b00, "b2b_done");
    start_transaction = 1'b1; done_step = 1'b1; step_ok = 1'b1;
    tick();
    done_step = 1'b0; step_ok = 1'b0;
    expect_out("b2b.done", 0, 0, 0);
    tick();
    expect_out("b2b.idle", 0, 0, 0);
    tick();
    start_transaction = 1'b0;
    expect_out("b2b.travel", 1, 1, 1);
    push(1'b0, 2'b11, "b2b_abort");
    do_abort();
    tick(); tick();

    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
